// File: rtl/sig_rom_provider.sv
// Loadable signal-word store: words arrive as WR_WIDTH-bit beats during LOAD and are served
// by address with one-cycle latency in SERVE. Out-of-range reads return zero with an error flag.
module sig_rom_provider #(
  parameter int unsigned ROM_SIG_WIDTH   = 100,
  parameter int unsigned SIG_ADDRS_WIDTH = 10,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned WR_WIDTH        = 32
) (
  input  logic                         clk_i,
  input  logic                         general_rst_i,
  input  logic                         wr_valid_i,
  input  logic [WR_WIDTH-1:0]          wr_data_i,
  output logic                         wr_ready_o,
  input  logic                         load_done_i,
  input  logic                         clear_i,
  input  logic                         rd_rom_signals_ld_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]   addrs_rom_signal_i,
  output logic [ROM_SIG_WIDTH-1:0]     rom_signals_data_o,
  output logic                         rom_sig_valid_o,
  output logic                         rd_err_o,
  output logic [$clog2(DEPTH+1)-1:0]   entry_count_o,
  output logic                         serving_o
);

  localparam int unsigned BEATS   = (ROM_SIG_WIDTH + WR_WIDTH - 1) / WR_WIDTH;
  localparam int unsigned BeatW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned MemIdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned StageW  = BEATS * WR_WIDTH;
  localparam int unsigned CmpW0   = (SIG_ADDRS_WIDTH > CntW) ? SIG_ADDRS_WIDTH : CntW;
  localparam int unsigned CmpW    = (CmpW0 > MemIdxW) ? CmpW0 : MemIdxW;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
  localparam logic [CntW-1:0]  Full     = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StServe} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [BeatW-1:0]          beat_q, beat_d;
  logic [StageW-1:0]         stage_q, stage_d, stage_merged;
  logic [ROM_SIG_WIDTH-1:0]  data_q;
  logic                      valid_q, err_q;

  logic [ROM_SIG_WIDTH-1:0]  mem_q [DEPTH];
  logic                      mem_we;
  logic [MemIdxW-1:0]        mem_waddr;
  logic [ROM_SIG_WIDTH-1:0]  mem_wdata;

  logic                      beat_fire, rd_fire, rd_oob;
  logic [CmpW-1:0]           addr_ext, cnt_ext;
  logic [MemIdxW-1:0]        rd_idx;

  assign wr_ready_o = (state_q != StServe) && (count_q < Full);
  assign beat_fire  = wr_valid_i && wr_ready_o;

  assign addr_ext = CmpW'(addrs_rom_signal_i);
  assign cnt_ext  = CmpW'(count_q);
  assign rd_oob   = (addr_ext >= cnt_ext);
  assign rd_idx   = addr_ext[MemIdxW-1:0];
  assign rd_fire  = rd_rom_signals_ld_i && (state_q == StServe) && !clear_i;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    beat_d       = beat_q;
    stage_d      = stage_q;
    mem_we       = 1'b0;
    mem_waddr    = count_q[MemIdxW-1:0];
    mem_wdata    = '0;
    stage_merged = stage_q;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_q == BeatW'(k)) begin
        stage_merged[k*WR_WIDTH +: WR_WIDTH] = wr_data_i;
      end
    end

    if (clear_i) begin
      state_d = StIdle;
      count_d = '0;
      beat_d  = '0;
      stage_d = '0;
    end else begin
      if (beat_fire) begin
        if (beat_q == LastBeat) begin
          mem_we    = 1'b1;
          mem_wdata = stage_merged[ROM_SIG_WIDTH-1:0];
          count_d   = count_q + CntW'(1);
          beat_d    = '0;
          stage_d   = '0;
        end else begin
          beat_d  = beat_q + BeatW'(1);
          stage_d = stage_merged;
        end
        if (state_q == StIdle) begin
          state_d = StLoad;
        end
      end
      // The beat above is folded in first; a still-partial entry commits zero-padded.
      if (load_done_i && (state_q != StServe)) begin
        if (beat_d != '0) begin
          mem_we    = 1'b1;
          mem_wdata = stage_d[ROM_SIG_WIDTH-1:0];
          count_d   = count_q + CntW'(1);
        end
        beat_d  = '0;
        stage_d = '0;
        state_d = StServe;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!general_rst_i) begin
      state_q <= StIdle;
      count_q <= '0;
      beat_q  <= '0;
      stage_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      stage_q <= stage_d;
      valid_q <= rd_fire;
      if (rd_fire) begin
        err_q  <= rd_oob;
        data_q <= rd_oob ? '0 : mem_q[rd_idx];
      end else begin
        err_q  <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; only committed entries are ever read back.
  always_ff @(posedge clk_i) begin
    if (general_rst_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rom_signals_data_o = data_q;
  assign rom_sig_valid_o    = valid_q;
  assign rd_err_o           = err_q;
  assign entry_count_o      = count_q;
  assign serving_o          = (state_q == StServe);

endmodule
